// File: rtl/pix_line_delay.sv
// Pixel-stream delay: LINES whole-line circular buffers followed by PIX free-running
// register stages. Output is masked to zero until the current frame has filled the line section.
module pix_line_delay #(
  parameter int DATA_W = 10,
  parameter int CH     = 1,
  parameter int IMG_W  = 640,
  parameter int LINES  = 2,
  parameter int PIX    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_sof,
  input  logic                 in_eol,
  input  logic                 bypass,
  output logic                 out_valid,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 primed,
  output logic                 err_len
);

  localparam int W    = CH * DATA_W;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int FILL = LINES * IMG_W;
  localparam int FW   = $clog2(FILL + 1);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);
  localparam logic [FW-1:0] FULL = FW'(FILL);

  logic [CW-1:0] col;
  logic [CW-1:0] wcol;
  logic [CW-1:0] col_nxt;
  logic [FW-1:0] fill;
  logic [W-1:0]  mem [LINES][IMG_W];
  logic [W-1:0]  tap;
  logic [W-1:0]  line_res;
  logic          sof_beat;
  logic          beat;

  logic [PIX-1:0] v_q;
  logic [PIX-1:0] s_q;
  logic [PIX-1:0] e_q;
  logic [W-1:0]   d_q [PIX];

  assign beat     = in_valid & ~sclr;
  assign sof_beat = in_valid & in_sof;
  // A start-of-frame beat always lands in column 0, whatever the pointer says.
  assign wcol     = sof_beat ? '0 : col;
  assign col_nxt  = (in_eol || wcol == LAST) ? '0 : wcol + CW'(1);
  assign primed   = (fill == FULL);
  assign tap      = mem[LINES-1][wcol];

  // The sof beat itself starts a fresh fill, so it is masked even if the old frame was primed.
  always_comb begin
    line_res = '0;
    if (bypass)
      line_res = in_data;
    else if (primed && !sof_beat)
      line_res = tap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      fill    <= '0;
      err_len <= 1'b0;
    end else if (sclr) begin
      col     <= '0;
      fill    <= '0;
      err_len <= 1'b0;
    end else if (in_valid) begin
      col <= col_nxt;
      if (in_sof)
        fill <= FW'(1);
      else if (!primed)
        fill <= fill + FW'(1);
      if ((in_eol && wcol != LAST) || (!in_eol && wcol == LAST))
        err_len <= 1'b1;
    end
  end

  // Non-blocking read of mem[n-1] gives read-before-write down the cascade.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[0][wcol] <= in_data;
      for (int n = 1; n < LINES; n++)
        mem[n][wcol] <= mem[n-1][wcol];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      s_q <= '0;
      e_q <= '0;
      for (int i = 0; i < PIX; i++)
        d_q[i] <= '0;
    end else if (sclr) begin
      v_q <= '0;
      s_q <= '0;
      e_q <= '0;
      for (int i = 0; i < PIX; i++)
        d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      s_q[0] <= in_valid & in_sof;
      e_q[0] <= in_valid & in_eol;
      d_q[0] <= in_valid ? line_res : '0;
      for (int i = 1; i < PIX; i++) begin
        v_q[i] <= v_q[i-1];
        s_q[i] <= s_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[PIX-1];
  assign out_sof   = s_q[PIX-1];
  assign out_eol   = e_q[PIX-1];
  assign out_data  = d_q[PIX-1];

endmodule

// File: tb/tb_pix_line_delay.sv
// Scoreboard bench for pix_line_delay at IMG_W=8, LINES=2, PIX=6: the driver queues expected beats,
// the monitor pops one per out_valid and checks data, flags and the 6-clock latency.
module tb_pix_line_delay;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       in_eol = 1'b0;
  logic       bypass = 1'b0;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_sof;
  logic       out_eol;
  logic       primed;
  logic       err_len;

  pix_line_delay #(.DATA_W(10), .CH(1), .IMG_W(8), .LINES(2), .PIX(6)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol), .bypass(bypass),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .primed(primed), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] d;
    logic       sof;
    logic       eol;
    logic       dc;
    int         t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per output beat.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          if (!e.dc) chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_sof", 32'(out_sof), 32'(e.sof));
          chk("out_eol", 32'(out_eol), 32'(e.eol));
          chk("latency", 32'(cyc - e.t), 32'd6);
        end
      end
    end
  end

  task automatic beat(input logic [9:0] d, input logic s, input logic e, input logic byp,
                      input logic [9:0] ex, input logic dc);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eol   = e;
    bypass   = byp;
    x.d = ex; x.sof = s; x.eol = e; x.dc = dc; x.t = cyc;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      bypass   = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // One 40-beat frame, data = beat index, eol every 8th beat; gap inserts idle clocks.
  task automatic frame40(input int gap);
    for (int k = 0; k < 40; k++) begin
      beat(10'(k), k == 0, (k % 8) == 7, 1'b0, (k >= 16) ? 10'(k - 16) : 10'd0, 1'b0);
      if (k == 15 || k == 16) chk("primed_fill", 32'(primed), 32'(k == 16));
      if (gap > 0) idle(gap);
    end
    idle(1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Continuous stream, then the same stream with idle clocks in between
    frame40(0);
    chk("err_len_clean", 32'(err_len), 32'd0);
    frame40(1);

    // Bypass passes data straight to the pixel section
    beat(10'h155, 1'b0, 1'b0, 1'b1, 10'h155, 1'b0);
    idle(1);
    drain();

    // Short line: 7 beats then eol; following line must restart at column 0
    @(negedge clk); sclr = 1'b1;
    @(negedge clk); sclr = 1'b0;
    chk("sclr_err_len", 32'(err_len), 32'd0);
    chk("sclr_primed", 32'(primed), 32'd0);
    begin
      int k = 0;
      for (int l = 0; l < 4; l++) begin
        for (int c = 0; c < ((l == 0) ? 7 : 8); c++) begin
          logic [9:0] ex;
          logic       dc;
          dc = 1'b0;
          if (k < 16) ex = 10'd0;
          else if (l == 2) begin ex = 10'(100 + c); dc = (c == 7); end
          else ex = 10'(110 + c);
          beat(10'(100 + 10 * l + c), k == 0, (l == 0) ? (c == 6) : (c == 7), 1'b0, ex, dc);
          if (l == 0 && c == 6) chk("err_len_before", 32'(err_len), 32'd0);
          if (l == 1 && c == 0) chk("err_len_short_line", 32'(err_len), 32'd1);
          k++;
        end
      end
    end
    idle(1);
    drain();
    chk("err_len_sticky", 32'(err_len), 32'd1);

    // Reset mid-stream after 20 beats
    for (int k = 0; k < 20; k++)
      beat(10'(200 + k), k == 0, (k % 8) == 7, 1'b0, (k >= 16) ? 10'(200 + k - 16) : 10'd0, 1'b0);
    idle(1);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_primed", 32'(primed), 32'd0);
    chk("midrst_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    chk("postrst_out_data", 32'(out_data), 32'd0);

    // Refill after reset, then a second sof at beat 24 restarts filling
    for (int k = 0; k < 24; k++) begin
      beat(10'(300 + k), k == 0, (k % 8) == 7, 1'b0, (k >= 16) ? 10'(300 + k - 16) : 10'd0, 1'b0);
      if (k == 15 || k == 16) chk("primed_refill", 32'(primed), 32'(k == 16));
    end
    for (int j = 0; j < 20; j++) begin
      beat(10'(400 + j), j == 0, (j % 8) == 7, 1'b0, (j >= 16) ? 10'(400 + j - 16) : 10'd0, 1'b0);
      if (j == 0) chk("primed_before_sof", 32'(primed), 32'd1);
      if (j == 1) chk("primed_drop_on_sof", 32'(primed), 32'd0);
      if (j == 15 || j == 16) chk("primed_resof", 32'(primed), 32'(j == 16));
    end
    idle(1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
